dpram_be: RTL

Parametrised true dual-port RAM with per-byte write enables and a selectable read latency of 1 or 2. It has a configurable read-during-write mode, deterministic write-write collision resolution, and a post-reset initialisation sweep that zeroes the array. It is the drop-in successor to the fixed-width dual-port RAM and sits behind the same per-port address/data interface, with added enable, valid and ready handshakes.

---
 rtl/dpram_pkg.sv | 24 ++
 rtl/dpram_be_rd_pipe.sv | 56 +++++
 rtl/dpram_be.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dpram_pkg.sv
// Shared types and the byte-lane merge helper for the byte-enable dual-port RAM.
package dpram_pkg;

  typedef enum logic {S_INIT, S_RUN} state_e;
  typedef enum logic {RDW_OLD, RDW_NEW} rdw_mode_e;

  // The merge helper works on the widest supported word; callers cast in and out.
  localparam int MAX_DATA_W = 1024;
  localparam int MAX_BE_W   = MAX_DATA_W / 8;

  function automatic logic [MAX_DATA_W-1:0] merge_be(
    input logic [MAX_DATA_W-1:0] old_w,
    input logic [MAX_DATA_W-1:0] new_w,
    input logic [MAX_BE_W-1:0]   be
  );
    logic [MAX_DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < MAX_BE_W; i++) begin
      if (be[i]) res[i*8 +: 8] = new_w[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_be_rd_pipe.sv
// Per-port read output register chain (RD_LAT stages) carrying data and valid.
module dpram_rd_pipe #(
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  if (RD_LAT == 2) begin : g_lat2
    logic [DATA_W-1:0] d0_q, d1_q;
    logic              ld0_q, v0_q, v1_q;

    // The second stage only advances behind a real load so dout holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d0_q  <= '0;
        d1_q  <= '0;
        ld0_q <= 1'b0;
        v0_q  <= 1'b0;
        v1_q  <= 1'b0;
      end else begin
        ld0_q <= load_i;
        v0_q  <= valid_i;
        v1_q  <= v0_q;
        if (load_i) d0_q <= data_i;
        if (ld0_q)  d1_q <= d0_q;
      end
    end

    assign data_o  = d1_q;
    assign valid_o = v1_q;
  end else begin : g_lat1
    logic [DATA_W-1:0] d0_q;
    logic              v0_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        d0_q <= '0;
        v0_q <= 1'b0;
      end else begin
        v0_q <= valid_i;
        if (load_i) d0_q <= data_i;
      end
    end

    assign data_o  = d0_q;
    assign valid_o = v0_q;
  end

endmodule

// File: rtl/dpram_be.sv
// True dual-port RAM with byte enables, init sweep, write-write arbitration (A wins).
//   state  | meaning
//   S_INIT | zeroing address cnt_q each cycle, ports ignored
//   S_RUN  | normal operation, terminal until reset
module dpram_be
  import dpram_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ready,
  output logic                 collision,
  input  logic                 en_a,
  input  logic                 we_a,
  input  logic [DATA_W/8-1:0]  be_a,
  input  logic [ADDR_W-1:0]    addr_a,
  input  logic [DATA_W-1:0]    din_a,
  output logic [DATA_W-1:0]    dout_a,
  output logic                 valid_a,
  input  logic                 en_b,
  input  logic                 we_b,
  input  logic [DATA_W/8-1:0]  be_b,
  input  logic [ADDR_W-1:0]    addr_b,
  input  logic [DATA_W-1:0]    din_b,
  output logic [DATA_W-1:0]    dout_b,
  output logic                 valid_b
);

  localparam int        DEPTH = 2 ** ADDR_W;
  localparam rdw_mode_e RDW   = (RDW_MODE == 1) ? RDW_NEW : RDW_OLD;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ready_q, collision_q;

  logic              run, wr_a, wr_b, rd_a, rd_b, ww_same;
  logic [DATA_W-1:0] old_a, old_b, new_a, new_b, wdata_a;
  logic [DATA_W-1:0] ld_data_a, ld_data_b;

  assign run     = (state_q == S_RUN);
  assign wr_a    = run & en_a & we_a;
  assign wr_b    = run & en_b & we_b;
  assign rd_a    = run & en_a & ~we_a;
  assign rd_b    = run & en_b & ~we_b;
  assign ww_same = wr_a & wr_b & (addr_a == addr_b);
  assign cnt_d   = cnt_q + ADDR_W'(1);

  assign old_a = mem[addr_a];
  assign old_b = mem[addr_b];
  assign new_a = DATA_W'(merge_be(MAX_DATA_W'(old_a), MAX_DATA_W'(din_a), MAX_BE_W'(be_a)));
  assign new_b = DATA_W'(merge_be(MAX_DATA_W'(old_b), MAX_DATA_W'(din_b), MAX_BE_W'(be_b)));

  // On a same-address collision A's write carries B's lanes underneath A's own.
  assign wdata_a = ww_same
    ? DATA_W'(merge_be(MAX_DATA_W'(new_b), MAX_DATA_W'(din_a), MAX_BE_W'(be_a)))
    : new_a;

  assign ld_data_a = (we_a && RDW == RDW_NEW) ? new_a : old_a;
  assign ld_data_b = (we_b && RDW == RDW_NEW) ? new_b : old_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q       <= cnt_d;
          collision_q <= 1'b0;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          collision_q <= ww_same;
        end
        default: begin
          state_q <= S_INIT;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // The array is deliberately not reset; the sweep clears it.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt_q] <= '0;
    end else begin
      if (wr_a)            mem[addr_a] <= wdata_a;
      if (wr_b && !ww_same) mem[addr_b] <= new_b;
    end
  end

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (run & en_a),
    .valid_i (rd_a),
    .data_i  (ld_data_a),
    .data_o  (dout_a),
    .valid_o (valid_a)
  );

  dpram_rd_pipe #(.DATA_W(DATA_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (run & en_b),
    .valid_i (rd_b),
    .data_i  (ld_data_b),
    .data_o  (dout_b),
    .valid_o (valid_b)
  );

  assign ready     = ready_q;
  assign collision = collision_q;

endmodule
